// File: rtl/refill_arbiter.sv
// refill_arbiter: round-robin share of one L2 refill port across tile I-cache refill interfaces.
// Optional REFILL_ARBITER_PERF_CNT_EN adds busy/stall cycle counters.
module refill_arbiter #(
  parameter int NumTiles  = 16,
  parameter int AddrWidth = 32,
  parameter int LineWidth = 128,
  parameter int LenWidth  = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumTiles-1:0]                 refill_qvalid_i,
  input  logic [NumTiles-1:0][AddrWidth-1:0]  refill_qaddr_i,
  input  logic [NumTiles-1:0][LenWidth-1:0]   refill_qlen_i,
  output logic [NumTiles-1:0]                 refill_qready_o,
  output logic [LineWidth-1:0]                refill_pdata_o,
  output logic [NumTiles-1:0]                 refill_pvalid_o,
  output logic                                refill_plast_o,
  input  logic [NumTiles-1:0]                 refill_pready_i,
  output logic                                mem_req_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [LineWidth-1:0]                mem_rdata_i
`ifdef REFILL_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]                         busy_cycles_o,
  output logic [31:0]                         stall_cycles_o
`endif
);
  localparam int IdxW = $clog2(NumTiles);
  localparam int OffW = $clog2(LineWidth / 8);
  localparam logic [NumTiles-1:0] One = NumTiles'(1);
  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;
  state_t state;
  logic [IdxW-1:0] rr_ptr, idx, sel, j;
  logic found;
  logic [AddrWidth-1:0] cur_addr;
  logic [LenWidth-1:0] remaining;
  logic [LineWidth-1:0] pdata;
  // first requester at or above rr_ptr, wrapping at NumTiles
  always_comb begin
    found = 1'b0;
    sel = '0;
    j = '0;
    for (int i = 0; i < NumTiles; i++) begin
      j = IdxW'((int'(rr_ptr) + i) % NumTiles);
      if (!found && refill_qvalid_i[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
  end
  assign refill_qready_o = (state == IDLE && found && !rst_i) ? One << sel : '0;
  assign refill_pvalid_o = (state == RESP) ? One << idx : '0;
  assign refill_plast_o  = state == RESP && remaining == '0;
  assign refill_pdata_o  = pdata;
  assign mem_req_o       = state == READ;
  assign mem_addr_o      = cur_addr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      pdata     <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          idx       <= sel;
          cur_addr  <= (refill_qaddr_i[sel] >> OffW) << OffW;
          remaining <= refill_qlen_i[sel];
          rr_ptr    <= (sel == IdxW'(NumTiles - 1)) ? '0 : sel + 1'b1;
          state     <= READ;
        end
        READ: if (mem_gnt_i) state <= WAIT;
        WAIT: if (mem_rvalid_i) begin
          pdata <= mem_rdata_i;
          state <= RESP;
        end
        RESP: if (refill_pready_i[idx]) begin
          if (remaining == '0) state <= IDLE;
          else begin
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + AddrWidth'(LineWidth / 8);
            state     <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef REFILL_ARBITER_PERF_CNT_EN
  logic [NumTiles-1:0] others;
  assign others = refill_qvalid_i & ~(One << idx);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_cycles_o  <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (state != IDLE && busy_cycles_o != '1) busy_cycles_o <= busy_cycles_o + 1'b1;
      if (state != IDLE && others != '0 && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: directed self-checking bench for refill_arbiter (default parameters).
module tb_refill_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] qvalid = '0, qready, pvalid, pready = '0;
  logic [15:0][31:0] qaddr = '0;
  logic [15:0][2:0] qlen = '0;
  logic [127:0] pdata, rdata = '0;
  logic plast, mem_req, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] mem_addr;
  int nchk = 0, nerr = 0;
`ifdef REFILL_ARBITER_PERF_CNT_EN
  logic [31:0] busy_cycles, stall_cycles;
`endif
  refill_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .refill_qvalid_i(qvalid), .refill_qaddr_i(qaddr), .refill_qlen_i(qlen),
    .refill_qready_o(qready), .refill_pdata_o(pdata), .refill_pvalid_o(pvalid),
    .refill_plast_o(plast), .refill_pready_i(pready),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
`ifdef REFILL_ARBITER_PERF_CNT_EN
    , .busy_cycles_o(busy_cycles), .stall_cycles_o(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  // one line from the READ cycle through the pready handshake
  task automatic beat(input logic [31:0] a, input logic last, input logic [127:0] d, input int t);
    gnt = 1'b1;
    #1;
    chk("beat_req", mem_req, 1'b1);
    chk("beat_addr", mem_addr, a);
    nxt;
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = d;
    #1;
    chk("wait_noreq", mem_req, 1'b0);
    nxt;
    rvalid = 1'b0;
    #1;
    chk("resp_pvalid", pvalid, 16'h1 << t);
    chk("resp_plast", plast, last);
    chk("resp_pdata", pdata, d);
    pready = 16'h1 << t;
    nxt;
    pready = '0;
  endtask
  initial begin
    nxt;
    nxt;
    rst = 1'b0;
    #1;
    chk("rst_qready", qready, 16'h0);
    chk("rst_pvalid", pvalid, 16'h0);
    chk("rst_plast", plast, 1'b0);
    chk("rst_pdata", pdata, 128'h0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_memaddr", mem_addr, 32'h0);
    nxt;
    // single beat, tile 3
    qvalid[3] = 1'b1;
    qaddr[3] = 32'h8001_0000;
    qlen[3] = 3'd0;
    #1;
    chk("single_qready", qready, 16'h0008);
    nxt;
    qvalid = '0;
    beat(32'h8001_0000, 1'b1, 128'hD00D_0001_CAFE, 3);
    #1;
    chk("single_idle_pvalid", pvalid, 16'h0);
    chk("single_idle_req", mem_req, 1'b0);
    // 4-beat burst, tile 0 (rr_ptr=4 wraps to 0)
    qvalid[0] = 1'b1;
    qaddr[0] = 32'h8001_0040;
    qlen[0] = 3'd3;
    #1;
    chk("burst_qready", qready, 16'h0001);
    nxt;
    qvalid = '0;
    #1;
    chk("burst_busy_qready", qready, 16'h0);
    beat(32'h8001_0040, 1'b0, 128'h11, 0);
    beat(32'h8001_0050, 1'b0, 128'h22, 0);
    beat(32'h8001_0060, 1'b0, 128'h33, 0);
    beat(32'h8001_0070, 1'b1, 128'h44, 0);
    #1;
    chk("burst_idle_pvalid", pvalid, 16'h0);
    // round robin between tiles 0 and 2 from rr_ptr=0
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    qvalid = 16'h0005;
    qaddr[0] = 32'h3000;
    qaddr[2] = 32'h4000;
    qlen[0] = 3'd0;
    qlen[2] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_qready", qready, (k % 2) ? 16'h0004 : 16'h0001);
      nxt;
      #1;
      chk("rr_busy_qready", qready, 16'h0);
      beat((k % 2) ? 32'h4000 : 32'h3000, 1'b1, 128'(k + 100), (k % 2) ? 2 : 0);
    end
    qvalid = '0;
    // backpressure and alignment, tile 1 (rr_ptr=3 wraps to 1)
    qvalid[1] = 1'b1;
    qaddr[1] = 32'h8001_0004;
    qlen[1] = 3'd0;
    #1;
    chk("bp_qready", qready, 16'h0002);
    nxt;
    qvalid = '0;
    gnt = 1'b1;
    #1;
    chk("align_addr", mem_addr, 32'h8001_0000);
    nxt;
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 128'hBEEF_0000_0000_0000_0000_0000_0000_5A5A;
    nxt;
    for (int k = 0; k < 5; k++) begin
      gnt = 1'b1;
      rvalid = 1'b1;
      rdata = 128'(k);
      pready = 16'hFFFD;
      #1;
      chk("bp_pvalid", pvalid, 16'h0002);
      chk("bp_pdata", pdata, 128'hBEEF_0000_0000_0000_0000_0000_0000_5A5A);
      chk("bp_noreq", mem_req, 1'b0);
      nxt;
    end
    gnt = 1'b0;
    rvalid = 1'b0;
    pready = 16'h0002;
    #1;
    chk("bp_plast", plast, 1'b1);
    nxt;
    pready = '0;
    #1;
    chk("bp_done_pvalid", pvalid, 16'h0);
    chk("bp_done_req", mem_req, 1'b0);
    // address wrap, tile 4 (rr_ptr=2)
    qvalid[4] = 1'b1;
    qaddr[4] = 32'hFFFF_FFF0;
    qlen[4] = 3'd1;
    #1;
    chk("wrap_qready", qready, 16'h0010);
    nxt;
    qvalid = '0;
    beat(32'hFFFF_FFF0, 1'b0, 128'hA1, 4);
    beat(32'h0000_0000, 1'b1, 128'hA2, 4);
    // reset during WAIT of beat 2, tile 6 (rr_ptr=5)
    qvalid[6] = 1'b1;
    qaddr[6] = 32'h1000;
    qlen[6] = 3'd3;
    #1;
    chk("rst_mid_qready", qready, 16'h0040);
    nxt;
    qvalid = '0;
    beat(32'h1000, 1'b0, 128'hB1, 6);
    gnt = 1'b1;
    #1;
    chk("rst_mid_addr2", mem_addr, 32'h1010);
    nxt;
    gnt = 1'b0;
    rst = 1'b1;
    nxt;
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 128'hBAD;
    #1;
    chk("abort_pvalid", pvalid, 16'h0);
    chk("abort_req", mem_req, 1'b0);
    chk("abort_plast", plast, 1'b0);
    chk("abort_pdata", pdata, 128'h0);
    nxt;
    rvalid = 1'b0;
    #1;
    chk("late_rvalid_pvalid", pvalid, 16'h0);
    chk("late_rvalid_req", mem_req, 1'b0);
    // tiles 5 and 9 request; reset coincides with the first handshake
    qvalid = 16'h0220;
    qaddr[5] = 32'h2000;
    qaddr[9] = 32'h9000;
    qlen[5] = 3'd0;
    qlen[9] = 3'd0;
    rst = 1'b1;
    #1;
    chk("rst_hs_qready", qready, 16'h0);
    nxt;
    rst = 1'b0;
    #1;
    chk("post_rst_qready", qready, 16'h0020);
    nxt;
    qvalid = '0;
    beat(32'h2000, 1'b1, 128'hC5, 5);
    #1;
    chk("final_pvalid", pvalid, 16'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
